// File: rtl/sqrt_square_check.sv
// Square-and-compare checker for the integer square-root datapath.
// Rebuilds root^2 with a 16-step shift-and-add and reports radicand - root^2 with a tolerance flag.
module sqrt_square_check #(
  parameter int          W_ROOT = 16,
  parameter int          W_RAD  = 32,
  parameter logic [31:0] TOL    = 32'd0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W_ROOT-1:0]       in_root,
  input  logic [W_RAD-1:0]        in_rad,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W_RAD-1:0]        out_square,
  output logic signed [W_RAD:0]   out_resid,
  output logic                    out_within_tol,
  output logic                    busy
);

  localparam int CNT_W = $clog2(W_ROOT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W_ROOT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [W_RAD:0]   TOL_X    = (W_RAD+1)'(TOL);
  localparam logic [W_RAD:0]   ONE_X    = (W_RAD+1)'(1);

  typedef enum logic [1:0] {IDLE, CALC, RESID, DONE} state_t;

  state_t              state;
  logic [W_ROOT-1:0]   root_q;
  logic [W_RAD-1:0]    rad_q;
  logic [W_RAD-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic signed [W_RAD:0] resid_c;

  // Partial product for bit k of the root: the root shifted left by k when that bit is set.
  function automatic logic [W_RAD-1:0] partial(input logic [W_ROOT-1:0] r,
                                               input logic [CNT_W-1:0]  k);
    logic [W_RAD-1:0] wide;
    wide = {{(W_RAD-W_ROOT){1'b0}}, r};
    return r[k] ? (wide << k) : '0;
  endfunction

  function automatic logic signed [W_RAD:0] residual(input logic [W_RAD-1:0] rad,
                                                     input logic [W_RAD-1:0] sq);
    return $signed({1'b0, rad}) - $signed({1'b0, sq});
  endfunction

  // Magnitude is taken at full residual width, so the most negative residual cannot wrap.
  function automatic logic tol_check(input logic signed [W_RAD:0] r);
    logic [W_RAD:0] u;
    logic [W_RAD:0] mag;
    u   = r;
    mag = u[W_RAD] ? (~u + ONE_X) : u;
    return mag <= TOL_X;
  endfunction

  assign resid_c  = residual(rad_q, acc);
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      root_q         <= '0;
      rad_q          <= '0;
      acc            <= '0;
      cnt            <= '0;
      out_valid      <= 1'b0;
      out_square     <= '0;
      out_resid      <= '0;
      out_within_tol <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            root_q <= in_root;
            rad_q  <= in_rad;
            acc    <= '0;
            cnt    <= '0;
            state  <= CALC;
          end
        end
        // Fixed-length accumulation: every bit is visited, zero bits included.
        CALC: begin
          acc <= acc + partial(root_q, cnt);
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) state <= RESID;
        end
        RESID: begin
          out_square     <= acc;
          out_resid      <= resid_c;
          out_within_tol <= tol_check(resid_c);
          out_valid      <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_square_check.sv
// Directed and randomized bench for sqrt_square_check; three instances differ only in TOL.
module tb_sqrt_square_check;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_root;
  logic [31:0] in_rad;

  logic        in_ready, out_valid, busy, wt0;
  logic [31:0] square;
  logic [32:0] resid;
  logic        in_ready_b, out_valid_b, busy_b, wt16;
  logic [31:0] square_b;
  logic [32:0] resid_b;
  logic        in_ready_c, out_valid_c, busy_c, wt9;
  logic [31:0] square_c;
  logic [32:0] resid_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sqrt_square_check #(.W_ROOT(16), .W_RAD(32), .TOL(32'd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_root(in_root), .in_rad(in_rad), .out_valid(out_valid), .out_ready(out_ready),
    .out_square(square), .out_resid(resid), .out_within_tol(wt0), .busy(busy));

  sqrt_square_check #(.W_ROOT(16), .W_RAD(32), .TOL(32'd16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_root(in_root), .in_rad(in_rad), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_square(square_b), .out_resid(resid_b), .out_within_tol(wt16), .busy(busy_b));

  sqrt_square_check #(.W_ROOT(16), .W_RAD(32), .TOL(32'd9)) dut9 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_root(in_root), .in_rad(in_rad), .out_valid(out_valid_c), .out_ready(out_ready),
    .out_square(square_c), .out_resid(resid_c), .out_within_tol(wt9), .busy(busy_c));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic check_results(input string tag, input logic [15:0] r, input logic [31:0] d);
    longint sq, rs, mag;
    logic [32:0] rs33;
    sq   = longint'(r) * longint'(r);
    rs   = longint'(d) - sq;
    mag  = (rs < 0) ? -rs : rs;
    rs33 = 33'(rs);
    chk({tag, "_square"}, {32'd0, square}, 64'(sq));
    chk({tag, "_resid"},  {31'd0, resid},  {31'd0, rs33});
    chk({tag, "_tol0"},   {63'd0, wt0},    {63'd0, mag <= 0});
    chk({tag, "_tol16"},  {63'd0, wt16},   {63'd0, mag <= 16});
    chk({tag, "_tol9"},   {63'd0, wt9},    {63'd0, mag <= 9});
  endtask

  task automatic do_txn(input string tag, input logic [15:0] r, input logic [31:0] d,
                        input int bp);
    int n;
    logic busy_lost;
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_root  = r;
    in_rad   = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_root  = 16'($urandom);
    in_rad   = $urandom;
    chk({tag, "_busy_t1"},     {63'd0, busy},     64'd1);
    chk({tag, "_in_ready_t1"}, {63'd0, in_ready}, 64'd0);
    n = 0;
    busy_lost = 1'b0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (busy !== 1'b1) busy_lost = 1'b1;
    end
    chk({tag, "_latency"},   64'(n), 64'd17);
    chk({tag, "_busy_held"}, {63'd0, busy_lost}, 64'd0);
    check_results(tag, r, d);
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_root  = 16'($urandom);
      in_rad   = $urandom;
      @(posedge clk);
      #1;
      chk({tag, "_bp_valid"},    {63'd0, out_valid}, 64'd1);
      chk({tag, "_bp_in_ready"}, {63'd0, in_ready},  64'd0);
      check_results({tag, "_bp"}, r, d);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_hs_valid"},    {63'd0, out_valid}, 64'd0);
    chk({tag, "_hs_busy"},     {63'd0, busy},      64'd0);
    chk({tag, "_hs_in_ready"}, {63'd0, in_ready},  64'd1);
  endtask

  initial begin
    logic [15:0] rr;
    logic [31:0] dd;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_root   = '0;
    in_rad    = '0;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy",      {63'd0, busy},      64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_square",    {32'd0, square},    64'd0);
    chk("rst_resid",     {31'd0, resid},     64'd0);
    chk("rst_tol",       {63'd0, wt0},       64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_txn("exact16",  16'h0010, 32'd256,        0);
    do_txn("maxroot",  16'hFFFF, 32'hFFFF_FFFF,  0);
    do_txn("neg10",    16'h000A, 32'd90,         0);
    do_txn("zeroroot", 16'h0000, 32'h1234_5678,  0);
    do_txn("bpress",   16'h0123, 32'h0001_4B00,  5);
    do_txn("after_bp", 16'h00FF, 32'd65000,      0);

    // Abort in the middle of the CALC iterations.
    @(negedge clk);
    in_valid = 1'b1;
    in_root  = 16'h1234;
    in_rad   = 32'h0100_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_busy",      {63'd0, busy},      64'd0);
    chk("abort_in_ready",  {63'd0, in_ready},  64'd1);
    chk("abort_square",    {32'd0, square},    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_txn("post_rst", 16'd3, 32'd10, 0);

    for (int i = 0; i < 8; i++) begin
      rr = 16'($urandom);
      if (i % 2 == 0) dd = $urandom;
      else dd = 32'(longint'(rr) * longint'(rr)) + 32'($urandom_range(0, 24)) - 32'd12;
      do_txn("rand", rr, dd, i % 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sqrt_square_check.md
Name: sqrt_square_check

Overview:
- Inverse-direction companion to the integer square-root datapath.
- Takes a 16-bit root and the 32-bit radicand it was derived from. Reconstructs root² with an iterative shift-and-add squarer, then produces the signed residual (radicand − root²) and a tolerance flag.
- Sits downstream of the sqrt unit, used for on-line error measurement of the approximate root. Valid/ready handshake on both sides.

Parameters:
- W_ROOT, 16, root width; iteration count equals W_ROOT.
- W_RAD, 32, radicand/square width; must equal 2*W_ROOT.
- TOL, 32'd0, maximum |residual| for which out_within_tol is asserted.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input operands valid.
- in_ready  output  1  block can accept operands.
- in_root  input  W_ROOT  root under test, unsigned.
- in_rad  input  W_RAD  original radicand, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_square  output  W_RAD  in_root², unsigned.
- out_resid  output  W_RAD+1  in_rad − in_root², two's complement.
- out_within_tol  output  1  |out_resid| <= TOL.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - out_valid, out_square, out_resid, out_within_tol, busy = 0.
  - Internal accumulator, counter and operand registers = 0.
  - in_ready=1, since it is decoded from state==IDLE.
- Reset asserted mid-operation:
  - Immediate abort; outputs go to reset values without waiting for a clock.
  - No partial result is ever presented.
- FSM states: IDLE, CALC, RESID, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch in_root and in_rad, clear acc and cnt, go to CALC.
  - Operands need not stay stable after acceptance.
- CALC:
  - in_ready=0.
  - Each edge: if root[cnt]=1 then acc <= acc + (root << cnt); cnt <= cnt+1.
  - On the edge where cnt==W_ROOT−1, the final add occurs and state goes to RESID.
  - Exactly W_ROOT (16) iterations. No early termination and no zero-skip, so latency is fixed.
- RESID (one edge):
  - out_square <= acc.
  - out_resid <= {1'b0,rad} − {1'b0,acc}, at 33-bit width.
  - out_within_tol <= (abs(resid) <= TOL), with abs computed at 33 bits unsigned so there is no overflow.
  - out_valid <= 1; state goes to DONE.
- DONE:
  - Outputs held stable while out_ready=0. out_valid never deasserts without a handshake.
  - On an edge with out_valid & out_ready: out_valid <= 0, state goes to IDLE.
  - in_ready rises the following cycle. There is no same-cycle accept, so throughput is at most 1 result per 19 cycles.
- Latency:
  - Acceptance edge T.
  - out_valid is high after edge T+17 (16 CALC edges T+1..T+16, RESID edge T+17).
- Width rules:
  - Maximum square is 0xFFFE0001, which fits in W_RAD, so acc never overflows.
  - out_resid range is −0xFFFE0001 .. +0xFFFFFFFF, representable in 33-bit two's complement.
- in_valid while busy: ignored, no side effects.
- out_ready while not out_valid: ignored.

Test Plan:
- root=0x0010, rad=256, TOL=0 → square=0x00000100, resid=0, within_tol=1; out_valid first high exactly 17 edges after the accept edge; busy high from T+1 to the handshake.
- root=0xFFFF, rad=0xFFFFFFFF, TOL=0 → square=0xFFFE0001, resid=33'h0_0001_FFFE, within_tol=0.
- root=0x000A, rad=90, TOL=16 → square=100, resid=33'h1_FFFF_FFF6 (−10), within_tol=1. Rerun with TOL=9 → within_tol=0.
- root=0x0000, rad=0x12345678 → square=0, resid=0x12345678; latency is still 17, with no early completion.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while pulsing in_valid with new operands → outputs bit-stable, in_ready=0, new operands not captured. Assert out_ready → out_valid=0 next edge, in_ready=1 next cycle, next transaction correct.
- Assert rst_n=0 asynchronously at CALC iteration 8 → out_valid and busy drop without a clock edge, in_ready=1. After release, accept root=3, rad=10 → square=9, resid=+1, latency 17.
